kf8259_interrupt_acknowledge: RTL and testbench
===============================================

Name: kf8259_interrupt_acknowledge

Overview:
- INTA-side sequencer for the KF8259: consumes the CPU interrupt-acknowledge pulse train and produces the controls that drive the in-service register (start_in_service, end_of_interrupt).
- Places the CALL opcode and address bytes (MCS-80/85 mode) or the vector byte (8086 mode) on the data bus.
- Sits between the priority resolver output and the in-service register / data-bus driver.

Parameters:
- None.

Ports:
- clock  in  1  system clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high
- interrupt_acknowledge_n  in  1  CPU INTA#, synchronous to clock
- interrupt_to_service  in  8  one-hot highest-priority unmasked request from the resolver (0 = none)
- u8086_or_mcs80_config  in  1  1 = 8086 mode, 0 = MCS-80/85 mode
- auto_eoi_config  in  1  1 = automatic EOI at the end of the last INTA pulse
- call_address_interval_4_or_8_config  in  1  1 = interval 4, 0 = interval 8
- vector_high  in  8  ICW2 byte (T7-T3 in 8086 mode; A15-A8 in MCS-80 mode)
- vector_low  in  3  ICW1 A7-A5
- start_in_service  out  1  one-cycle pulse that sets the in-service bit
- interrupt_acknowledged  out  8  one-hot level latched for the current sequence
- end_of_interrupt  out  8  one-cycle automatic EOI pulse, one-hot
- out_data  out  8  byte driven to the data bus
- out_data_enable  out  1  data-bus drive enable
- ack_in_progress  out  1  high from the first INTA falling edge until the sequence completes

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): all outputs 0, state IDLE, previous-INTA sample = 1. The partial sequence is discarded; no EOI is issued.
- Edge detection: inta_prev is registered each falling clock edge.
  - Fall event = inta_prev==1 and interrupt_acknowledge_n==0.
  - Rise event = inta_prev==0 and interrupt_acknowledge_n==1.
  - All outputs are registered on the same edge that detects the event (one-edge latency).
- States: IDLE, PULSE1, WAIT2, PULSE2, WAIT3, PULSE3.
- IDLE, on fall:
  - Latch the mode flags and level.
  - If interrupt_to_service != 0: interrupt_acknowledged <= interrupt_to_service and start_in_service = 1 for exactly one cycle.
  - If interrupt_to_service == 0 (spurious): interrupt_acknowledged <= 8'h80, no start_in_service.
  - ack_in_progress <= 1; go to PULSE1.
  - MCS-80 mode: out_data <= 8'hCD, out_data_enable <= 1.
  - 8086 mode: out_data_enable stays 0.
- PULSEn, on rise: out_data_enable <= 0, out_data <= 0.
  - If this was the last pulse (pulse 2 in 8086 mode, pulse 3 in MCS-80 mode): go to IDLE, ack_in_progress <= 0.
  - Otherwise go to the next WAITn.
- WAIT2, on fall: go to PULSE2, out_data_enable <= 1. Let L = binary encoding of the latched one-hot level.
  - 8086 mode: out_data <= {vector_high[7:3], L}.
  - MCS-80 mode, interval 4: out_data <= {vector_low[2:0], L, 2'b00}.
  - MCS-80 mode, interval 8: out_data <= {vector_low[2:1], L, 3'b000}.
- WAIT3, on fall: go to PULSE3, out_data <= vector_high, out_data_enable <= 1.
- Automatic EOI: on the last rise, if auto_eoi_config (latched) is 1 and the sequence was not spurious, end_of_interrupt = interrupt_acknowledged for one cycle. Otherwise end_of_interrupt stays 0.
- Config inputs that change mid-sequence have no effect until the next IDLE fall.
- interrupt_to_service changes after the first fall are ignored.
- interrupt_acknowledged holds its value after the sequence completes until the next first fall.
- No event while INTA is steady. A rise in IDLE, or a fall in a PULSE state, is impossible by construction and is ignored.

Test Plan:
- 8086 mode, interrupt_to_service=8'h08, vector_high=8'h40, two INTA pulses -> start_in_service pulses once on the first fall; out_data_enable=0 during pulse 1; out_data=8'h43 during pulse 2; ack_in_progress drops on the second rise.
- MCS-80 mode, interval 4, vector_low=3'b101, vector_high=8'h12, level 8'h04 -> pulse 1 8'hCD, pulse 2 8'hA8, pulse 3 8'h12; enable low between pulses.
- MCS-80 mode, interval 8, vector_low=3'b110, level 8'h80 -> pulse 2 8'hF8.
- auto_eoi_config=1, 8086 mode, level 8'h02 -> end_of_interrupt=8'h02 for one cycle on the second rise. Spurious run (interrupt_to_service=0) -> interrupt_acknowledged=8'h80, no start_in_service, no EOI, vector uses L=7.
- Reset asserted during WAIT2 -> all outputs 0 immediately. A following INTA fall starts a fresh sequence with start_in_service.
- interrupt_to_service changes 8'h01->8'h10 between pulses, and u8086_or_mcs80_config toggles mid-sequence -> vector still uses L=0 and the originally latched mode.

Source files
------------

// File: rtl/kf8259_interrupt_acknowledge_if.sv
// Signal bundle between the KF8259 INTA sequencer and its surroundings
// (CPU INTA#, priority resolver, ICW config, in-service register, data bus).
interface kf8259_interrupt_acknowledge_if;
  logic       interrupt_acknowledge_n;
  logic [7:0] interrupt_to_service;
  logic       u8086_or_mcs80_config;
  logic       auto_eoi_config;
  logic       call_address_interval_4_or_8_config;
  logic [7:0] vector_high;
  logic [2:0] vector_low;
  logic       start_in_service;
  logic [7:0] interrupt_acknowledged;
  logic [7:0] end_of_interrupt;
  logic [7:0] out_data;
  logic       out_data_enable;
  logic       ack_in_progress;
  logic [2:0] state_dbg;

  // Handshake: no valid/ready; INTA# is a level sampled on every falling
  // clock edge and its edges (not its level) advance the sequence.
  modport slave (
    input  interrupt_acknowledge_n, interrupt_to_service, u8086_or_mcs80_config,
           auto_eoi_config, call_address_interval_4_or_8_config, vector_high, vector_low,
    output start_in_service, interrupt_acknowledged, end_of_interrupt, out_data,
           out_data_enable, ack_in_progress, state_dbg
  );

  modport master (
    output interrupt_acknowledge_n, interrupt_to_service, u8086_or_mcs80_config,
           auto_eoi_config, call_address_interval_4_or_8_config, vector_high, vector_low,
    input  start_in_service, interrupt_acknowledged, end_of_interrupt, out_data,
           out_data_enable, ack_in_progress, state_dbg
  );
endinterface

// File: rtl/kf8259_interrupt_acknowledge.sv
// KF8259 interrupt-acknowledge sequencer: walks the INTA# pulse train and
// emits in-service controls plus the CALL/vector bytes for the data bus.
module kf8259_interrupt_acknowledge (
  input logic                           clock,
  input logic                           reset,
  kf8259_interrupt_acknowledge_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE1 = 3'd1;
  localparam logic [2:0] S_WAIT2  = 3'd2;
  localparam logic [2:0] S_PULSE2 = 3'd3;
  localparam logic [2:0] S_WAIT3  = 3'd4;
  localparam logic [2:0] S_PULSE3 = 3'd5;

  logic [2:0] r_state;
  logic       r_inta_prev;
  logic       r_mode_8086;
  logic       r_auto_eoi;
  logic       r_interval4;
  logic       r_spurious;
  logic       r_start_in_service;
  logic [7:0] r_ack;
  logic [7:0] r_eoi;
  logic [7:0] r_data;
  logic       r_data_en;
  logic       r_ack_in_progress;

  logic       w_fall;
  logic       w_rise;
  logic       w_last_pulse;
  logic [2:0] w_level;
  logic [7:0] w_vector_byte;

  assign w_fall = r_inta_prev & ~bus.interrupt_acknowledge_n;
  assign w_rise = ~r_inta_prev & bus.interrupt_acknowledge_n;
  assign w_last_pulse = (r_state == S_PULSE3) || ((r_state == S_PULSE2) && r_mode_8086);

  // The latched level is one-hot (or 8'h80 for a spurious request).
  always_comb begin
    w_level = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_ack[i]) w_level = 3'(i);
    end
  end

  always_comb begin
    w_vector_byte = 8'h00;
    if (r_mode_8086)
      w_vector_byte = {bus.vector_high[7:3], w_level};
    else if (r_interval4)
      w_vector_byte = {bus.vector_low, w_level, 2'b00};
    else
      w_vector_byte = {bus.vector_low[2:1], w_level, 3'b000};
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_inta_prev        <= 1'b1;
      r_mode_8086        <= 1'b0;
      r_auto_eoi         <= 1'b0;
      r_interval4        <= 1'b0;
      r_spurious         <= 1'b0;
      r_start_in_service <= 1'b0;
      r_ack              <= 8'h00;
      r_eoi              <= 8'h00;
      r_data             <= 8'h00;
      r_data_en          <= 1'b0;
      r_ack_in_progress  <= 1'b0;
    end else begin
      r_inta_prev        <= bus.interrupt_acknowledge_n;
      r_start_in_service <= 1'b0;
      r_eoi              <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_mode_8086       <= bus.u8086_or_mcs80_config;
            r_auto_eoi        <= bus.auto_eoi_config;
            r_interval4       <= bus.call_address_interval_4_or_8_config;
            r_spurious        <= (bus.interrupt_to_service == 8'h00);
            r_ack_in_progress <= 1'b1;
            r_state           <= S_PULSE1;
            if (bus.interrupt_to_service != 8'h00) begin
              r_ack              <= bus.interrupt_to_service;
              r_start_in_service <= 1'b1;
            end else begin
              r_ack <= 8'h80;
            end
            // MCS-80/85 gets the CALL opcode on the first pulse; 8086 drives nothing.
            if (!bus.u8086_or_mcs80_config) begin
              r_data    <= 8'hCD;
              r_data_en <= 1'b1;
            end
          end
        end
        S_PULSE1, S_PULSE2, S_PULSE3: begin
          if (w_rise) begin
            r_data_en <= 1'b0;
            r_data    <= 8'h00;
            if (w_last_pulse) begin
              r_state           <= S_IDLE;
              r_ack_in_progress <= 1'b0;
              if (r_auto_eoi && !r_spurious) r_eoi <= r_ack;
            end else begin
              r_state <= (r_state == S_PULSE1) ? S_WAIT2 : S_WAIT3;
            end
          end
        end
        S_WAIT2: begin
          if (w_fall) begin
            r_state   <= S_PULSE2;
            r_data    <= w_vector_byte;
            r_data_en <= 1'b1;
          end
        end
        S_WAIT3: begin
          if (w_fall) begin
            r_state   <= S_PULSE3;
            r_data    <= bus.vector_high;
            r_data_en <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_in_service       = r_start_in_service;
  assign bus.interrupt_acknowledged = r_ack;
  assign bus.end_of_interrupt       = r_eoi;
  assign bus.out_data               = r_data;
  assign bus.out_data_enable        = r_data_en;
  assign bus.ack_in_progress        = r_ack_in_progress;
  assign bus.state_dbg              = r_state;

endmodule

// File: tb/tb_kf8259_interrupt_acknowledge.sv
// Bench for the KF8259 INTA sequencer: fixed vector table, corner-case
// sequences, then randomized INTA trains against a behavioural model.
module tb_kf8259_interrupt_acknowledge;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  kf8259_interrupt_acknowledge_if ifc ();

  kf8259_interrupt_acknowledge dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [26:0] exp_q[$];

  function automatic logic [26:0] pack_obs(logic sis, logic [7:0] ack, logic [7:0] eoi,
                                           logic [7:0] data, logic oe, logic aip);
    return {sis, ack, eoi, data, oe, aip};
  endfunction

  function automatic logic [26:0] dut_obs();
    return pack_obs(ifc.start_in_service, ifc.interrupt_acknowledged, ifc.end_of_interrupt,
                    ifc.out_data, ifc.out_data_enable, ifc.ack_in_progress);
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got {sis,ack,eoi,data,oe,aip}=%07h expected %07h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_prev, m_active, m_mode, m_auto, m_int4, m_spur;
  int         m_k;
  logic       m_sis, m_oe, m_aip;
  logic [7:0] m_ack, m_eoi, m_data;

  task automatic model_reset();
    m_prev = 1'b1; m_active = 1'b0; m_k = 0;
    m_mode = 1'b0; m_auto = 1'b0; m_int4 = 1'b0; m_spur = 1'b0;
    m_sis = 1'b0; m_oe = 1'b0; m_aip = 1'b0;
    m_ack = 8'h00; m_eoi = 8'h00; m_data = 8'h00;
  endtask

  function automatic logic [7:0] pulse_byte(int k);
    logic [2:0] lvl;
    logic [7:0] vh;
    logic [2:0] vl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m_ack == (8'd1 << i)) lvl = 3'(i);
    vh = ifc.vector_high;
    vl = ifc.vector_low;
    if (k == 3) return vh;
    if (m_mode) return {vh[7:3], lvl};
    if (m_int4) return {vl, lvl, 2'b00};
    return {vl[2:1], lvl, 3'b000};
  endfunction

  task automatic model_step();
    logic fall, rise;
    fall   = m_prev && !ifc.interrupt_acknowledge_n;
    rise   = !m_prev && ifc.interrupt_acknowledge_n;
    m_prev = ifc.interrupt_acknowledge_n;
    m_sis  = 1'b0;
    m_eoi  = 8'h00;
    if (fall && !m_active) begin
      m_active = 1'b1;
      m_k      = 1;
      m_mode   = ifc.u8086_or_mcs80_config;
      m_auto   = ifc.auto_eoi_config;
      m_int4   = ifc.call_address_interval_4_or_8_config;
      m_spur   = (ifc.interrupt_to_service == 8'h00);
      m_ack    = m_spur ? 8'h80 : ifc.interrupt_to_service;
      m_sis    = !m_spur;
      m_aip    = 1'b1;
      if (!m_mode) begin
        m_data = 8'hCD;
        m_oe   = 1'b1;
      end
    end else if (fall) begin
      m_k++;
      m_data = pulse_byte(m_k);
      m_oe   = 1'b1;
    end else if (rise && m_active) begin
      m_data = 8'h00;
      m_oe   = 1'b0;
      if (m_k == (m_mode ? 2 : 3)) begin
        m_active = 1'b0;
        m_aip    = 1'b0;
        if (m_auto && !m_spur) m_eoi = m_ack;
      end
    end
  endtask

  // One falling edge: model steps alongside the DUT, outputs sampled 1ns later.
  task automatic tick(input bit use_model, input string name);
    logic [26:0] e;
    @(negedge clock);
    if (reset) model_reset();
    else model_step();
    exp_q.push_back(pack_obs(m_sis, m_ack, m_eoi, m_data, m_oe, m_aip));
    #1;
    e = exp_q.pop_front();
    if (use_model) check(name, dut_obs(), e);
  endtask

  // ---------------- driver ----------------
  task automatic set_cfg(input logic [7:0] its, input logic mode, input logic ae,
                         input logic i4, input logic [7:0] vh, input logic [2:0] vl);
    ifc.interrupt_to_service                = its;
    ifc.u8086_or_mcs80_config               = mode;
    ifc.auto_eoi_config                     = ae;
    ifc.call_address_interval_4_or_8_config = i4;
    ifc.vector_high                         = vh;
    ifc.vector_low                          = vl;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       inta;
    logic [7:0] its;
    logic       mode, ae, i4;
    logic [7:0] vh;
    logic [2:0] vl;
    logic       sis;
    logic [7:0] ack, eoi, data;
    logic       oe, aip;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic inta, input logic [7:0] its, input logic mode, input logic ae,
                     input logic i4, input logic [7:0] vh, input logic [2:0] vl,
                     input logic sis, input logic [7:0] ack, input logic [7:0] eoi,
                     input logic [7:0] data, input logic oe, input logic aip);
    vec_t v;
    v.inta = inta; v.its = its; v.mode = mode; v.ae = ae; v.i4 = i4; v.vh = vh; v.vl = vl;
    v.sis = sis; v.ack = ack; v.eoi = eoi; v.data = data; v.oe = oe; v.aip = aip;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] vh_v;
    logic [7:0] its_v;
    int npulse;

    // 8086, level 08, vector 40
    add(1, 8'h08, 1, 0, 0, 8'h40, 3'd0,  0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 8'h08, 1, 0, 0, 8'h40, 3'd0,  1, 8'h08, 8'h00, 8'h00, 0, 1);
    add(0, 8'h08, 1, 0, 0, 8'h40, 3'd0,  0, 8'h08, 8'h00, 8'h00, 0, 1);
    add(1, 8'h08, 1, 0, 0, 8'h40, 3'd0,  0, 8'h08, 8'h00, 8'h00, 0, 1);
    add(0, 8'h08, 1, 0, 0, 8'h40, 3'd0,  0, 8'h08, 8'h00, 8'h43, 1, 1);
    add(1, 8'h08, 1, 0, 0, 8'h40, 3'd0,  0, 8'h08, 8'h00, 8'h00, 0, 0);
    // MCS-80 interval 4, level 04
    add(1, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h08, 8'h00, 8'h00, 0, 0);
    add(0, 8'h04, 0, 0, 1, 8'h12, 3'd5,  1, 8'h04, 8'h00, 8'hCD, 1, 1);
    add(1, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h04, 8'h00, 8'h00, 0, 1);
    add(0, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h04, 8'h00, 8'hA8, 1, 1);
    add(1, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h04, 8'h00, 8'h00, 0, 1);
    add(0, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h04, 8'h00, 8'h12, 1, 1);
    add(1, 8'h04, 0, 0, 1, 8'h12, 3'd5,  0, 8'h04, 8'h00, 8'h00, 0, 0);
    // MCS-80 interval 8, level 80, auto EOI
    add(1, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h04, 8'h00, 8'h00, 0, 0);
    add(0, 8'h80, 0, 1, 0, 8'h12, 3'd6,  1, 8'h80, 8'h00, 8'hCD, 1, 1);
    add(1, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h00, 8'h00, 0, 1);
    add(0, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h00, 8'hF8, 1, 1);
    add(1, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h00, 8'h00, 0, 1);
    add(0, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h00, 8'h12, 1, 1);
    add(1, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h80, 8'h00, 0, 0);
    add(1, 8'h80, 0, 1, 0, 8'h12, 3'd6,  0, 8'h80, 8'h00, 8'h00, 0, 0);
    // 8086 auto EOI, level 02
    add(0, 8'h02, 1, 1, 0, 8'h40, 3'd0,  1, 8'h02, 8'h00, 8'h00, 0, 1);
    add(1, 8'h02, 1, 1, 0, 8'h40, 3'd0,  0, 8'h02, 8'h00, 8'h00, 0, 1);
    add(0, 8'h02, 1, 1, 0, 8'h40, 3'd0,  0, 8'h02, 8'h00, 8'h41, 1, 1);
    add(1, 8'h02, 1, 1, 0, 8'h40, 3'd0,  0, 8'h02, 8'h02, 8'h00, 0, 0);
    add(1, 8'h02, 1, 1, 0, 8'h40, 3'd0,  0, 8'h02, 8'h00, 8'h00, 0, 0);
    // 8086 spurious with auto EOI: no start, no EOI, level 7
    add(0, 8'h00, 1, 1, 0, 8'h40, 3'd0,  0, 8'h80, 8'h00, 8'h00, 0, 1);
    add(1, 8'h00, 1, 1, 0, 8'h40, 3'd0,  0, 8'h80, 8'h00, 8'h00, 0, 1);
    add(0, 8'h00, 1, 1, 0, 8'h40, 3'd0,  0, 8'h80, 8'h00, 8'h47, 1, 1);
    add(1, 8'h00, 1, 1, 0, 8'h40, 3'd0,  0, 8'h80, 8'h00, 8'h00, 0, 0);
    add(1, 8'h00, 1, 1, 0, 8'h40, 3'd0,  0, 8'h80, 8'h00, 8'h00, 0, 0);

    reset = 1'b1;
    ifc.interrupt_acknowledge_n = 1'b1;
    set_cfg(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    model_reset();
    tick(1, "reset_hold");
    tick(1, "reset_hold");
    check("reset_state", dut_obs(), 27'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      ifc.interrupt_acknowledge_n = tbl[i].inta;
      set_cfg(tbl[i].its, tbl[i].mode, tbl[i].ae, tbl[i].i4, tbl[i].vh, tbl[i].vl);
      tick(0, "");
      check($sformatf("tbl[%0d]", i), dut_obs(),
            pack_obs(tbl[i].sis, tbl[i].ack, tbl[i].eoi, tbl[i].data, tbl[i].oe, tbl[i].aip));
    end

    // Reset landing in WAIT2 discards the sequence immediately
    set_cfg(8'h04, 1'b0, 1'b1, 1'b1, 8'h12, 3'd5);
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "rst_seq_p1");
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "rst_seq_w2");
    #2 reset = 1'b1;
    #1 check("reset_async", dut_obs(), 27'd0);
    model_reset();
    tick(1, "reset_mid");
    tick(1, "reset_mid");
    reset = 1'b0;
    tick(1, "post_reset_idle");
    ifc.interrupt_to_service = 8'h20;
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "restart_p1");
    check("restart_sis", {26'd0, ifc.start_in_service}, 27'd1);
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "restart_w2");
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "restart_p2");
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "restart_w3");
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "restart_p3");
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "restart_end");
    tick(1, "restart_idle");

    // Level and mode changing after the first fall must be ignored
    vh_v = 8'hA5;
    set_cfg(8'h01, 1'b1, 1'b0, 1'b0, vh_v, 3'd3);
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "midchg_p1");
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "midchg_w2");
    ifc.interrupt_to_service = 8'h10;
    ifc.u8086_or_mcs80_config = 1'b0;
    ifc.call_address_interval_4_or_8_config = 1'b1;
    ifc.interrupt_acknowledge_n = 1'b0; tick(1, "midchg_p2");
    check("midchg_vector", {19'd0, ifc.out_data}, {19'd0, vh_v[7:3], 3'b000});
    ifc.interrupt_acknowledge_n = 1'b1; tick(1, "midchg_end");
    check("midchg_done", {26'd0, ifc.ack_in_progress}, 27'd0);
    tick(1, "midchg_idle");

    // Randomized INTA trains
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick(1, "rnd_reset");
        tick(1, "rnd_reset");
        reset = 1'b0;
      end
      its_v = ($urandom_range(0, 8) == 8) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
      set_cfg(its_v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 3'($urandom));
      npulse = ifc.u8086_or_mcs80_config ? 2 : 3;
      repeat ($urandom_range(0, 2)) tick(1, "rnd_idle");
      for (int p = 0; p < npulse; p++) begin
        ifc.interrupt_acknowledge_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick(1, "rnd_low");
        if ($urandom_range(0, 3) == 0) begin
          ifc.interrupt_to_service = 8'($urandom);
          ifc.u8086_or_mcs80_config = 1'($urandom_range(0, 1));
          ifc.auto_eoi_config = 1'($urandom_range(0, 1));
          ifc.call_address_interval_4_or_8_config = 1'($urandom_range(0, 1));
        end
        ifc.interrupt_acknowledge_n = 1'b1;
        repeat ($urandom_range(1, 3)) tick(1, "rnd_high");
      end
    end
    tick(1, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
